// File: rtl/z80_daisy_irqctl.sv
`default_nettype none
// ============================================================================
// Module   : z80_daisy_irqctl
// Purpose  : Fixed-priority, nesting interrupt controller that replaces a Z80
//            peripheral daisy chain. Latches rising-edge requests, drives /INT,
//            supplies the IM2 vector during acknowledge and retires the
//            in-service source on RETI.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_SRC        number of sources (1..8), source 0 is highest priority
//   VECTOR_BASE  IM2 vector of source 0 (bit 0 must be 0)
// Ports
//   I_CLK        system clock
//   I_RESET      asynchronous active-high reset
//   I_CLKEN      CPU clock enable, all state advances only when 1
//   I_REQ        per-source request, rising-edge sensitive
//   I_MASK       per-source mask, 1 = masked (only with Z80_DAISY_IRQ_MASK_EN)
//   I_SPM1       interrupt acknowledge (M1 & IORQ)
//   I_RETI       one-clken pulse after ED 4D is fetched
//   O_INT_n      CPU /INT, active low
//   O_VECTOR     IM2 vector, valid while O_VEC_OE=1
//   O_VEC_OE     data-bus drive enable for the vector
//   O_IEO        1 when no source is pending or in service
// Configuration
//   Z80_DAISY_IRQ_MASK_EN  adds I_MASK; masked sources are not eligible
// ============================================================================
module z80_daisy_irqctl #(
  parameter int          N_SRC       = 4,
  parameter logic [7:0]  VECTOR_BASE = 8'h00
) (
  input  logic              I_CLK,
  input  logic              I_RESET,
  input  logic              I_CLKEN,
  input  logic [N_SRC-1:0]  I_REQ,
`ifdef Z80_DAISY_IRQ_MASK_EN
  input  logic [N_SRC-1:0]  I_MASK,
`endif
  input  logic              I_SPM1,
  input  logic              I_RETI,
  output logic              O_INT_n,
  output logic [7:0]        O_VECTOR,
  output logic              O_VEC_OE,
  output logic              O_IEO
);

  localparam int c_win_w = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_ack  = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [N_SRC-1:0]    r_req_q;
  logic [N_SRC-1:0]    r_pend;
  logic [N_SRC-1:0]    r_ius;
  logic [c_win_w-1:0]  r_win;

  logic [N_SRC-1:0]    w_mask;
  logic [N_SRC-1:0]    w_edge;
  logic [N_SRC-1:0]    w_elig;
  logic                w_any_elig;
  logic [c_win_w-1:0]  w_win_nxt;
  logic [N_SRC-1:0]    w_win_oh;
  logic [N_SRC-1:0]    w_ius_low;
  logic [N_SRC-1:0]    w_commit_oh;
  logic [N_SRC-1:0]    w_reti_clr;
  logic                w_latch;
  logic                w_commit;
  logic                w_int_n;
  logic                w_vec_oe;

`ifdef Z80_DAISY_IRQ_MASK_EN
  assign w_mask = I_MASK;
`else
  assign w_mask = '0;
`endif

  assign w_edge = I_REQ & ~r_req_q;

  // A source is eligible only if nothing at its own or higher priority is in
  // service; the running OR carries that blocking down the priority order.
  always_comb begin
    logic acc;
    acc    = 1'b0;
    w_elig = '0;
    for (int i = 0; i < N_SRC; i++) begin
      acc       = acc | r_ius[i];
      w_elig[i] = r_pend[i] & ~acc & ~w_mask[i];
    end
  end

  assign w_any_elig = |w_elig;

  // Lowest-index eligible source wins.
  always_comb begin
    w_win_nxt = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_win_nxt = c_win_w'(i);
      end
    end
  end

  always_comb begin
    w_win_oh = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_win_oh[i] = (r_win == c_win_w'(i));
    end
  end

  // Isolate the lowest set bit: the innermost (highest-priority) nesting level.
  assign w_ius_low   = r_ius & (~r_ius + N_SRC'(1));
  assign w_commit_oh = {N_SRC{w_commit}} & w_win_oh;
  assign w_reti_clr  = {N_SRC{I_RETI}} & w_ius_low;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_state <= c_st_idle;
    end else if (I_CLKEN) begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_any_elig) begin
          w_state_nxt = c_st_req;
        end
      end
      c_st_req: begin
        if (!w_any_elig) begin
          w_state_nxt = c_st_idle;
        end else if (I_SPM1) begin
          w_state_nxt = c_st_ack;
          w_latch     = 1'b1;
        end
      end
      c_st_ack: begin
        if (!I_SPM1) begin
          w_state_nxt = c_st_idle;
          w_commit    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    w_int_n  = 1'b1;
    w_vec_oe = 1'b0;
    case (r_state)
      c_st_req: w_int_n  = 1'b0;
      c_st_ack: w_vec_oe = 1'b1;
      default: begin
        w_int_n  = 1'b1;
        w_vec_oe = 1'b0;
      end
    endcase
  end

  assign O_INT_n  = w_int_n;
  assign O_VEC_OE = w_vec_oe;
  // 8-bit add wraps mod 256; r_win is 0 out of reset so this reads VECTOR_BASE.
  assign O_VECTOR = VECTOR_BASE + {{(7 - c_win_w){1'b0}}, r_win, 1'b0};
  assign O_IEO    = ~|(r_pend | r_ius);

  // ---------------------------------------------------------------- datapath
  // A request edge on the committing source re-sets pend (set wins); RETI
  // clears from the pre-commit ius before the new in-service bit is OR'd in.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      r_req_q <= '0;
      r_pend  <= '0;
      r_ius   <= '0;
      r_win   <= '0;
    end else if (I_CLKEN) begin
      r_req_q <= I_REQ;
      r_pend  <= (r_pend & ~w_commit_oh) | w_edge;
      r_ius   <= (r_ius & ~w_reti_clr) | w_commit_oh;
      if (w_latch) begin
        r_win <= w_win_nxt;
      end
    end
  end

endmodule
`default_nettype wire
